// File: rtl/dmem_responder.sv
// dmem_responder
//   Slave end of the MEM-stage load/store request/response handshake.
//   Word-organised SRAM with byte-lane write enables, a fixed number of
//   wait states between request accept and response, and range/alignment
//   error reporting. Only whole words move through here; sub-word
//   extraction and sign extension belong to the load/store unit.
//
// Ports
//   clk          core clock, all state changes on the rising edge
//   reset        synchronous reset, active high
//   req_valid_i  request present
//   req_ready_o  request can be accepted this cycle
//   req_we_i     1 = store, 0 = load
//   req_addr_i   byte address
//   req_be_i     store byte-lane enables (bit n -> wdata[8n+7:8n])
//   req_wdata_i  store data
//   rsp_valid_o  response present
//   rsp_ready_i  requester takes the response this cycle
//   rsp_rdata_o  load data; 0 for stores and errored requests
//   rsp_err_o    request was out of range or misaligned
module dmem_responder #(
  parameter int          DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0001_0000,
  parameter int          WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_we_i,
  input  logic [31:0] req_addr_i,
  input  logic [3:0]  req_be_i,
  input  logic [31:0] req_wdata_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_rdata_o,
  output logic        rsp_err_o
);

  localparam int          AW       = $clog2(DEPTH_WORDS);
  // 33-bit end address so a window touching 4 GB cannot wrap.
  localparam logic [32:0] END_ADDR = {1'b0, BASE_ADDR} + 33'(DEPTH_WORDS) * 33'd4;
  localparam logic [3:0]  CNT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_e;

  state_e          state_q;
  logic [3:0]      cnt_q;
  logic            we_q;
  logic            err_q;
  logic [AW-1:0]   idx_q;
  logic [3:0]      be_q;
  logic [31:0]     wdata_q;
  logic            rsp_valid_q;
  logic            rsp_err_q;
  logic            rd_sel_q;
  logic [31:0]     rd_word_q;

  logic [31:0]     mem [DEPTH_WORDS];

  logic            accept;
  logic            req_err;
  logic [AW-1:0]   req_idx;

  assign accept  = req_valid_i & req_ready_o;
  assign req_idx = AW'((req_addr_i - BASE_ADDR) >> 2);
  assign req_err = (req_addr_i[1:0] != 2'b00)
                 | ({1'b0, req_addr_i} <  {1'b0, BASE_ADDR})
                 | ({1'b0, req_addr_i} >= END_ADDR);

  // Array access happens on the edge that enters RESP. With no wait states
  // that edge is the accept edge itself, so the live request fields drive the
  // array; otherwise the captured copy does.
  logic            mem_go;
  logic            mem_we;
  logic            mem_err;
  logic [AW-1:0]   mem_idx;
  logic [3:0]      mem_be;
  logic [31:0]     mem_wdata;

  if (WAIT_CYCLES == 0) begin : g_direct
    assign mem_go    = accept;
    assign mem_we    = req_we_i;
    assign mem_err   = req_err;
    assign mem_idx   = req_idx;
    assign mem_be    = req_be_i;
    assign mem_wdata = req_wdata_i;
  end else begin : g_captured
    assign mem_go    = (state_q == ST_WAIT) && (cnt_q == 4'd0);
    assign mem_we    = we_q;
    assign mem_err   = err_q;
    assign mem_idx   = idx_q;
    assign mem_be    = be_q;
    assign mem_wdata = wdata_q;
  end

  // Reset on the entry edge aborts the request: nothing is written or read.
  logic mem_wr;
  logic mem_rd;
  assign mem_wr = mem_go & ~reset &  mem_we & ~mem_err;
  assign mem_rd = mem_go & ~reset & ~mem_we & ~mem_err;

  always_ff @(posedge clk) begin
    if (mem_wr) begin
      for (int b = 0; b < 4; b++) begin
        if (mem_be[b]) mem[mem_idx][8*b +: 8] <= mem_wdata[8*b +: 8];
      end
    end
    if (mem_rd) rd_word_q <= mem[mem_idx];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 4'd0;
      we_q        <= 1'b0;
      err_q       <= 1'b0;
      idx_q       <= '0;
      be_q        <= 4'd0;
      wdata_q     <= 32'd0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rd_sel_q    <= 1'b0;
    end else if (accept) begin
      // Reachable from IDLE, or from RESP while the old response transfers.
      we_q    <= req_we_i;
      err_q   <= req_err;
      idx_q   <= req_idx;
      be_q    <= req_be_i;
      wdata_q <= req_wdata_i;
      if (WAIT_CYCLES == 0) begin
        state_q     <= ST_RESP;
        rsp_valid_q <= 1'b1;
        rsp_err_q   <= req_err;
        rd_sel_q    <= ~req_we_i & ~req_err;
      end else begin
        state_q     <= ST_WAIT;
        cnt_q       <= CNT_INIT;
        rsp_valid_q <= 1'b0;
      end
    end else begin
      case (state_q)
        ST_IDLE: ;
        ST_WAIT: begin
          if (cnt_q == 4'd0) begin
            state_q     <= ST_RESP;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= err_q;
            rd_sel_q    <= ~we_q & ~err_q;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        ST_RESP: begin
          if (rsp_ready_i) begin
            state_q     <= ST_IDLE;
            rsp_valid_q <= 1'b0;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign req_ready_o = (state_q == ST_IDLE) | ((state_q == ST_RESP) & rsp_ready_i);
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_err_o   = rsp_err_q;
  assign rsp_rdata_o = rd_sel_q ? rd_word_q : 32'd0;

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder
//   Two responders share the clock: dut_a with one wait state and dut_b with
//   none. Directed vectors, backpressure and reset-abort sequences run on
//   dut_a, zero-wait streaming on dut_b, then randomized traffic on dut_a
//   against an array-based reference model.
module tb_dmem_responder;

  localparam logic [31:0] BASE  = 32'h0001_0000;
  localparam int          DEPTH = 64;
  localparam int          WA    = 1;

  logic clk;
  logic reset;

  logic        a_req_valid, a_req_ready, a_req_we, a_rsp_valid, a_rsp_ready, a_rsp_err;
  logic [31:0] a_req_addr, a_req_wdata, a_rsp_rdata;
  logic [3:0]  a_req_be;
  logic        b_req_valid, b_req_ready, b_req_we, b_rsp_valid, b_rsp_ready, b_rsp_err;
  logic [31:0] b_req_addr, b_req_wdata, b_rsp_rdata;
  logic [3:0]  b_req_be;

  dmem_responder #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE), .WAIT_CYCLES(WA)) dut_a (
    .clk(clk), .reset(reset),
    .req_valid_i(a_req_valid), .req_ready_o(a_req_ready), .req_we_i(a_req_we),
    .req_addr_i(a_req_addr), .req_be_i(a_req_be), .req_wdata_i(a_req_wdata),
    .rsp_valid_o(a_rsp_valid), .rsp_ready_i(a_rsp_ready),
    .rsp_rdata_o(a_rsp_rdata), .rsp_err_o(a_rsp_err)
  );

  dmem_responder #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE), .WAIT_CYCLES(0)) dut_b (
    .clk(clk), .reset(reset),
    .req_valid_i(b_req_valid), .req_ready_o(b_req_ready), .req_we_i(b_req_we),
    .req_addr_i(b_req_addr), .req_be_i(b_req_be), .req_wdata_i(b_req_wdata),
    .rsp_valid_o(b_rsp_valid), .rsp_ready_i(b_rsp_ready),
    .rsp_rdata_o(b_rsp_rdata), .rsp_err_o(b_rsp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference model: plain word array indexed by byte offset / 4.
  logic [31:0] mm [DEPTH];

  function automatic bit m_err(input logic [31:0] a);
    return (a[1:0] != 2'b00) || (a < BASE) || (a >= BASE + 32'(4 * DEPTH));
  endfunction

  task automatic m_apply(input bit we, input logic [31:0] a, input logic [3:0] be,
                         input logic [31:0] wd, output logic [31:0] er, output bit ee);
    int idx;
    ee = m_err(a);
    er = 32'd0;
    if (!ee) begin
      idx = int'((a - BASE) / 4);
      if (we) begin
        for (int b = 0; b < 4; b++)
          if (be[b]) mm[idx][8*b +: 8] = wd[8*b +: 8];
      end else begin
        er = mm[idx];
      end
    end
  endtask

  // One complete transaction on dut_a; holds off rsp_ready for 'hold' cycles
  // once the response is up and checks it stays put meanwhile.
  task automatic txn(input bit we, input logic [31:0] addr, input logic [3:0] be,
                     input logic [31:0] wd, input int hold,
                     output logic [31:0] rd, output bit e);
    int n;
    @(negedge clk);
    a_req_valid = 1'b1; a_req_we = we; a_req_addr = addr; a_req_be = be; a_req_wdata = wd;
    a_rsp_ready = 1'b0;
    n = 0;
    while (!a_req_ready && n < 20) begin @(negedge clk); n++; end
    check("accept_timeout", 32'(n < 20), 32'd1);
    @(posedge clk);
    #1 a_req_valid = 1'b0;
    n = 0;
    while (n < 20) begin
      @(negedge clk);
      n++;
      if (a_rsp_valid) break;
    end
    check("latency", n, 1 + WA);
    rd = a_rsp_rdata;
    e  = a_rsp_err;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check("hold_valid", a_rsp_valid, 1'b1);
      check("hold_rdata", a_rsp_rdata, rd);
    end
    a_rsp_ready = 1'b1;
    @(posedge clk);
    #1 a_rsp_ready = 1'b0;
    $display("txn we=%0d addr=%h be=%h wd=%h -> rdata=%h err=%0d", we, addr, be, wd, rd, e);
  endtask

  typedef struct {
    bit          we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wd;
    logic [31:0] er;
    bit          ee;
  } vec_t;

  vec_t tbl [18];

  initial begin : timeout
    #500000;
    $display("FAIL global_timeout");
    $fatal(1, "simulation did not finish");
  end

  initial begin : main
    logic [31:0] rd, er;
    bit          e, ee;
    logic [31:0] sd [8];

    reset = 1'b1;
    a_req_valid = 0; a_req_we = 0; a_req_addr = 0; a_req_be = 0; a_req_wdata = 0; a_rsp_ready = 0;
    b_req_valid = 0; b_req_we = 0; b_req_addr = 0; b_req_be = 0; b_req_wdata = 0; b_rsp_ready = 0;

    tbl[0]  = '{1, BASE + 0,   4'hF, 32'h0BAD_F00D, 32'h0,          0};
    tbl[1]  = '{1, BASE + 8,   4'hF, 32'hDEAD_BEEF, 32'h0,          0};
    tbl[2]  = '{0, BASE + 8,   4'h0, 32'h0,         32'hDEAD_BEEF,  0};
    tbl[3]  = '{1, BASE + 12,  4'hF, 32'h1122_3344, 32'h0,          0};
    tbl[4]  = '{1, BASE + 12,  4'h5, 32'hAABB_CCDD, 32'h0,          0};
    tbl[5]  = '{0, BASE + 12,  4'h0, 32'h0,         32'h11BB_33DD,  0};
    tbl[6]  = '{0, BASE + 2,   4'h0, 32'h0,         32'h0,          1};
    tbl[7]  = '{0, BASE + 256, 4'h0, 32'h0,         32'h0,          1};
    tbl[8]  = '{0, BASE - 4,   4'h0, 32'h0,         32'h0,          1};
    tbl[9]  = '{1, BASE + 10,  4'hF, 32'h0,         32'h0,          1};
    tbl[10] = '{0, BASE + 8,   4'h0, 32'h0,         32'hDEAD_BEEF,  0};
    tbl[11] = '{1, BASE + 8,   4'h0, 32'h5555_5555, 32'h0,          0};
    tbl[12] = '{0, BASE + 8,   4'h0, 32'h0,         32'hDEAD_BEEF,  0};
    tbl[13] = '{1, BASE + 252, 4'hF, 32'hCAFE_F00D, 32'h0,          0};
    tbl[14] = '{0, BASE + 252, 4'h0, 32'h0,         32'hCAFE_F00D,  0};
    tbl[15] = '{0, 32'hFFFF_FFFC, 4'h0, 32'h0,      32'h0,          1};
    tbl[16] = '{1, BASE + 4,   4'hF, 32'h5555_5555, 32'h0,          0};
    tbl[17] = '{0, BASE + 6,   4'h0, 32'h0,         32'h0,          1};

    repeat (3) @(negedge clk);
    reset = 1'b0;
    check("rst_a_valid", a_rsp_valid, 1'b0);
    check("rst_a_err",   a_rsp_err,   1'b0);
    check("rst_a_rdata", a_rsp_rdata, 32'd0);
    check("rst_a_ready", a_req_ready, 1'b1);
    check("rst_b_valid", b_rsp_valid, 1'b0);
    check("rst_b_ready", b_req_ready, 1'b1);

    // Directed vectors.
    for (int i = 0; i < 18; i++) begin
      txn(tbl[i].we, tbl[i].addr, tbl[i].be, tbl[i].wd, i % 3, rd, e);
      check($sformatf("vec%0d_rdata", i), rd, tbl[i].er);
      check($sformatf("vec%0d_err", i), e, tbl[i].ee);
      m_apply(tbl[i].we, tbl[i].addr, tbl[i].be, tbl[i].wd, er, ee);
    end

    // Backpressure: response held 5 cycles with a second request waiting,
    // then both transfer on the same edge.
    @(negedge clk);
    a_req_valid = 1; a_req_we = 0; a_req_addr = BASE + 8; a_req_be = 0; a_rsp_ready = 0;
    @(posedge clk);
    #1 a_req_addr = BASE + 12;
    @(negedge clk);
    for (int h = 0; h < 5; h++) begin
      @(negedge clk);
      check("bp_valid", a_rsp_valid, 1'b1);
      check("bp_rdata", a_rsp_rdata, 32'hDEAD_BEEF);
      check("bp_ready", a_req_ready, 1'b0);
    end
    a_rsp_ready = 1'b1;
    #1 check("bp_release_ready", a_req_ready, 1'b1);
    @(posedge clk);
    #1 begin a_req_valid = 0; a_rsp_ready = 0; end
    @(negedge clk);
    check("bp_second_wait", a_rsp_valid, 1'b0);
    @(negedge clk);
    check("bp_second_valid", a_rsp_valid, 1'b1);
    check("bp_second_rdata", a_rsp_rdata, 32'h11BB_33DD);
    a_rsp_ready = 1'b1;
    @(posedge clk);
    #1 a_rsp_ready = 1'b0;
    $display("txn backpressure pair done");

    // Reset during WAIT of a store aborts it.
    @(negedge clk);
    a_req_valid = 1; a_req_we = 1; a_req_addr = BASE; a_req_be = 4'hF; a_req_wdata = 32'h1234_5678;
    @(posedge clk);
    #1 a_req_valid = 0;
    @(negedge clk);
    check("abort_in_wait", a_rsp_valid, 1'b0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_ready", a_req_ready, 1'b1);
    check("abort_rdata", a_rsp_rdata, 32'd0);
    for (int h = 0; h < 3; h++) begin
      @(negedge clk);
      check("abort_no_rsp", a_rsp_valid, 1'b0);
    end
    $display("txn reset-abort store addr=%h", BASE);
    txn(0, BASE, 4'h0, 32'h0, 0, rd, e);
    check("abort_readback", rd, 32'h0BAD_F00D);

    // Zero-wait streaming on dut_b: 8 stores then 8 loads, one per cycle.
    for (int k = 0; k < 8; k++) sd[k] = $urandom;
    for (int pass = 0; pass < 2; pass++) begin
      @(negedge clk);
      b_rsp_ready = 1; b_req_valid = 1; b_req_we = (pass == 0); b_req_be = 4'hF;
      b_req_addr = (pass == 0) ? BASE : BASE + 28; b_req_wdata = sd[0];
      for (int k = 0; k < 8; k++) begin
        @(posedge clk);
        @(negedge clk);
        check("stream_valid", b_rsp_valid, 1'b1);
        check("stream_ready", b_req_ready, 1'b1);
        check("stream_err", b_rsp_err, 1'b0);
        check($sformatf("stream%0d_rdata%0d", pass, k), b_rsp_rdata,
              (pass == 0) ? 32'd0 : sd[7 - k]);
        $display("txn stream pass=%0d k=%0d rdata=%h", pass, k, b_rsp_rdata);
        if (k < 7) begin
          b_req_addr  = (pass == 0) ? BASE + 32'(4 * (k + 1)) : BASE + 32'(4 * (6 - k));
          b_req_wdata = sd[k + 1];
        end else begin
          b_req_valid = 0;
        end
      end
    end
    @(negedge clk);
    check("stream_drained", b_rsp_valid, 1'b0);
    b_rsp_ready = 0;

    // Randomized traffic on dut_a: define every word, then mixed traffic.
    for (int w = 0; w < DEPTH; w++) begin
      logic [31:0] d;
      d = $urandom;
      m_apply(1, BASE + 32'(4 * w), 4'hF, d, er, ee);
      txn(1, BASE + 32'(4 * w), 4'hF, d, 0, rd, e);
      check("init_err", e, ee);
    end
    for (int i = 0; i < 300; i++) begin
      bit          we;
      logic [31:0] a, d;
      logic [3:0]  be;
      int          r;
      we = 1'($urandom);
      be = 4'($urandom);
      d  = $urandom;
      r  = int'($urandom_range(0, 9));
      if (r < 7)       a = BASE + 32'(4 * $urandom_range(0, DEPTH - 1));
      else if (r == 7) a = BASE + 32'(4 * $urandom_range(0, DEPTH - 1)) + 32'($urandom_range(1, 3));
      else if (r == 8) a = BASE - 32'(4 * $urandom_range(1, 4));
      else             a = BASE + 32'(4 * DEPTH) + 32'(4 * $urandom_range(0, 3));
      m_apply(we, a, be, d, er, ee);
      txn(we, a, be, d, int'($urandom_range(0, 2)), rd, e);
      check($sformatf("rnd%0d_rdata", i), rd, er);
      check($sformatf("rnd%0d_err", i), e, ee);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
